// File: rtl/key_expand_iter.sv
// key_expand_iter: iterative AES-128 key expansion, one round key per transfer.
// Define KEYEXP_RCON_LUT_EN for a table-based Rcon; default uses an xtime register.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb8145ede0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // entry 0 sits in the top byte, so the bit offset is (255-a)*8
    logic [10:0] off;
    assign off = {~a, 3'b000};
    assign y   = SBOX[off +: 8];
endmodule

module key_expand_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_index,
    output logic         rk_valid,
    output logic         rk_last,
    input  logic         rk_ready
);
    typedef enum logic {
        IDLE,
        EXPAND
    } state_t;

    state_t      state;
    logic [7:0]  rcon;
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, sub, t;
    logic [31:0] n0, n1, n2, n3;
    logic        key_xfer;
    logic        rk_xfer;

    assign key_xfer = key_valid & key_ready;
    assign rk_xfer  = rk_valid & rk_ready;

    assign {w0, w1, w2, w3} = rk_data;
    assign rot = {w3[23:0], w3[31:24]};

    aes_sbox u_sb0 (.a(rot[31:24]), .y(sub[31:24]));
    aes_sbox u_sb1 (.a(rot[23:16]), .y(sub[23:16]));
    aes_sbox u_sb2 (.a(rot[15:8]),  .y(sub[15:8]));
    aes_sbox u_sb3 (.a(rot[7:0]),   .y(sub[7:0]));

    assign t  = sub ^ {rcon, 24'h0};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

`ifdef KEYEXP_RCON_LUT_EN
    // Rcon for the round being produced, i.e. round index+1
    function automatic logic [7:0] rcon_lut(input logic [3:0] r);
        logic [7:0] v;
        v = 8'h00;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    assign rcon = rcon_lut(rk_index + 4'd1);
`else
    logic [7:0] rcon_q;

    assign rcon = rcon_q;

    // Rcon walks by GF(2^8) doubling, one step per accepted round key
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcon_q <= 8'h01;
        end else if (key_xfer) begin
            rcon_q <= 8'h01;
        end else if (rk_xfer && rk_index != 4'd10) begin
            rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        end
    end
`endif

    // control FSM with registered handshake and round-key outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            key_ready <= 1'b1;
            rk_valid  <= 1'b0;
            rk_last   <= 1'b0;
            rk_index  <= 4'd0;
            rk_data   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (key_xfer) begin
                        state     <= EXPAND;
                        key_ready <= 1'b0;
                        rk_data   <= key_in;
                        rk_index  <= 4'd0;
                        rk_valid  <= 1'b1;
                        rk_last   <= 1'b0;
                    end
                end
                EXPAND: begin
                    if (rk_xfer) begin
                        if (rk_index == 4'd10) begin
                            state     <= IDLE;
                            key_ready <= 1'b1;
                            rk_valid  <= 1'b0;
                            rk_last   <= 1'b0;
                        end else begin
                            rk_data  <= {n0, n1, n2, n3};
                            rk_index <= rk_index + 4'd1;
                            rk_last  <= (rk_index == 4'd9);
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_key_expand_iter.sv
// tb_key_expand_iter: directed vectors and handshake corner cases
// for the iterative AES-128 key expander.

module tb_key_expand_iter;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_index;
    logic         rk_valid;
    logic         rk_last;
    logic         rk_ready;

    always #5 clk = ~clk;

    key_expand_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rk_data   (rk_data),
        .rk_index  (rk_index),
        .rk_valid  (rk_valid),
        .rk_last   (rk_last),
        .rk_ready  (rk_ready)
    );

    typedef struct {
        logic [127:0] key;
        int           idx;
        logic [127:0] rk;
    } vec_t;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_KEY = 128'h0;
    localparam logic [127:0] ONES_KEY = {128{1'b1}};

    logic [127:0] fips_rk [11];
    vec_t         tbl [14];
    logic [127:0] got [11];
    int           cyc [11];
    int           last_cyc;
    int           kr_cyc;
    int           last_cnt;
    int           n_cmp = 0;
    int           n_err = 0;
    logic [127:0] prev_key;
    int           wcnt;
    logic [127:0] alt_key;

    task automatic chk(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!key_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {127'h0, key_ready}, 128'h1);
    endtask

    task automatic expand(input logic [127:0] k);
        for (int i = 0; i < 11; i++) begin
            got[i] = '0;
            cyc[i] = -1;
        end
        last_cyc = -1;
        kr_cyc   = -1;
        last_cnt = 0;
        @(posedge clk);
        #1;
        key_in    = k;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (rk_valid && rk_index <= 4'd10) begin
                got[rk_index] = rk_data;
                if (cyc[rk_index] < 0) cyc[rk_index] = n;
            end
            if (rk_last) begin
                last_cnt++;
                last_cyc = n;
            end
            if (key_ready && kr_cyc < 0) kr_cyc = n;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fips_rk[0]  = FIPS_KEY;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int i = 0; i < 11; i++) tbl[i] = '{FIPS_KEY, i, fips_rk[i]};
        tbl[11] = '{ZERO_KEY, 0, 128'h0};
        tbl[12] = '{ZERO_KEY, 1, 128'h62636363626363636263636362636363};
        tbl[13] = '{ZERO_KEY, 2, 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa};

        // reset state
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_in    = '0;
        rk_ready  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_key_ready", {127'h0, key_ready}, 128'h1);
        chk("rst_rk_valid", {127'h0, rk_valid}, 128'h0);
        chk("rst_rk_last", {127'h0, rk_last}, 128'h0);
        chk("rst_rk_index", {124'h0, rk_index}, 128'h0);
        chk("rst_rk_data", rk_data, 128'h0);

        // key accepted on the very first edge after reset release
        rst_n     = 1'b1;
        key_in    = FIPS_KEY;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        @(negedge clk);
        chk("first_rk_valid", {127'h0, rk_valid}, 128'h1);
        chk("first_rk_index", {124'h0, rk_index}, 128'h0);
        chk("first_rk_data", rk_data, FIPS_KEY);
        wait_idle();

        // table-driven round-key vectors, rk_ready held high
        for (int i = 0; i < 14; i++) begin
            if (i == 0 || tbl[i].key !== prev_key) begin
                expand(tbl[i].key);
                prev_key = tbl[i].key;
                chk("rk_last_cycle", 128'(last_cyc), 128'd11);
                chk("rk_last_count", 128'(last_cnt), 128'd1);
                chk("key_ready_cycle", 128'(kr_cyc), 128'd12);
            end
            chk($sformatf("rk%0d_data[%0d]", tbl[i].idx, i),
                got[tbl[i].idx], tbl[i].rk);
            chk($sformatf("rk%0d_cycle[%0d]", tbl[i].idx, i),
                128'(cyc[tbl[i].idx]), 128'(tbl[i].idx + 1));
        end

        // back-pressure: hold index 4 for five cycles
        @(posedge clk);
        #1;
        key_in    = FIPS_KEY;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        wcnt = 0;
        while (!(rk_valid && rk_index == 4'd4) && wcnt < 20) begin
            @(negedge clk);
            wcnt++;
        end
        chk("stall_reach", {124'h0, rk_index}, 128'd4);
        rk_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk($sformatf("stall_idx[%0d]", s), {124'h0, rk_index}, 128'd4);
            chk($sformatf("stall_data[%0d]", s), rk_data, fips_rk[4]);
        end
        chk("stall_valid", {127'h0, rk_valid}, 128'h1);
        rk_ready = 1'b1;
        for (int i = 0; i < 11; i++) got[i] = '0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (rk_valid && rk_index <= 4'd10) got[rk_index] = rk_data;
        end
        for (int i = 5; i <= 10; i++)
            chk($sformatf("resume_rk%0d", i), got[i], fips_rk[i]);
        wait_idle();

        // key_valid held high with changing keys during expansion
        @(posedge clk);
        #1;
        key_in    = FIPS_KEY;
        key_valid = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 14; n++) begin
            if (n > 1) @(posedge clk);
            #1;
            alt_key = (n % 2 == 1) ? ONES_KEY : ZERO_KEY;
            key_in  = alt_key;
            @(negedge clk);
            if (n <= 11) begin
                chk($sformatf("busy_ready[%0d]", n),
                    {127'h0, key_ready}, 128'h0);
                chk($sformatf("busy_rk[%0d]", n), rk_data, fips_rk[n-1]);
            end
            if (n == 11)
                chk("busy_last", {127'h0, rk_last}, 128'h1);
            if (n == 12) begin
                chk("busy_ready_back", {127'h0, key_ready}, 128'h1);
                chk("busy_valid_drop", {127'h0, rk_valid}, 128'h0);
            end
            if (n == 13) begin
                chk("second_idx", {124'h0, rk_index}, 128'h0);
                chk("second_rk0", rk_data, ZERO_KEY);
            end
            if (n == 14)
                chk("second_rk1", rk_data, tbl[12].rk);
        end
        key_valid = 1'b0;
        wait_idle();

        // reset mid-expansion at index 6
        @(posedge clk);
        #1;
        key_in    = FIPS_KEY;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        wcnt = 0;
        while (!(rk_valid && rk_index == 4'd6) && wcnt < 20) begin
            @(negedge clk);
            wcnt++;
        end
        chk("abort_reach", {124'h0, rk_index}, 128'd6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", {127'h0, rk_valid}, 128'h0);
        chk("abort_ready", {127'h0, key_ready}, 128'h1);
        chk("abort_index", {124'h0, rk_index}, 128'h0);
        chk("abort_data", rk_data, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            chk($sformatf("abort_quiet[%0d]", s),
                {127'h0, rk_valid}, 128'h0);
        end
        expand(ZERO_KEY);
        chk("post_abort_rk0", got[0], ZERO_KEY);
        chk("post_abort_rk1", got[1], tbl[12].rk);
        chk("post_abort_rk2", got[2], tbl[13].rk);
        chk("post_abort_cyc0", 128'(cyc[0]), 128'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/key_expand_iter.md
KEY_EXPAND_ITER -- requirements
Module: key_expand_iter

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port key_in  input  128  AES-128 cipher key; byte 0 in [127:120].
REQ-004 SHALL have port key_valid  input  1  key_in valid.
REQ-005 SHALL have port key_ready  output  1  block can accept a new key.
REQ-006 SHALL have port rk_data  output  128  current round key, word w[4i] in [127:96].
REQ-007 SHALL have port rk_index  output  4  round number i of rk_data, 0..10.
REQ-008 SHALL have port rk_valid  output  1  rk_data/rk_index valid.
REQ-009 SHALL have port rk_last  output  1  high with rk_valid when rk_index==10.
REQ-010 SHALL have port rk_ready  input  1  downstream accepts round key.

Function
REQ-011 SHALL implement FSM IDLE -> EXPAND -> IDLE; key_ready=1 only in IDLE.
REQ-012 Key transfer SHALL occur on a clk edge with key_valid&key_ready; key_in is captured there, FSM enters EXPAND, and key_valid is ignored outside IDLE.
REQ-013 Cycle after key transfer SHALL present rk_valid=1, rk_index=0, rk_data=captured key.
REQ-014 Round-key transfer SHALL occur on an edge with rk_valid&rk_ready; with rk_ready low, rk_data/rk_index/rk_valid SHALL hold stable.
REQ-015 On transfer of index i<10, the next cycle SHALL present index i+1 with next key: t=SubWord(RotWord(w3)) xor {Rcon[i+1],24'h0}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
REQ-016 RotWord SHALL be rotate-left one byte; SubWord SHALL apply the FIPS-197 S-box to each of the four bytes combinationally (4 S-box instances).
REQ-017 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36.
REQ-018 On transfer of index 10, rk_valid SHALL drop next cycle, FSM SHALL return to IDLE and key_ready SHALL assert the same cycle.
REQ-019 Latency with rk_ready held high: RK0 at transfer+1 cycle, RK10 at transfer+11, key_ready at transfer+12; throughput one key per 12 cycles.
REQ-020 No new key SHALL be accepted on the cycle RK10 transfers (key_ready is 0 then).
REQ-021 rk_last SHALL equal rk_valid & (rk_index==10).

Reset
REQ-022 rst_n low SHALL immediately force FSM=IDLE, key_ready=1, rk_valid=0, rk_last=0, rk_index=0, rk_data=0, Rcon state to round 1.
REQ-023 Reset during EXPAND SHALL abort the expansion; no further rk_valid until a new key transfer after rst_n deasserts.
REQ-024 First key transfer SHALL be possible on the first rising edge with rst_n high.

Configuration
REQ-025 Macro KEYEXP_RCON_LUT_EN defined: Rcon SHALL come from a 10-entry constant table indexed by round.
REQ-026 Macro KEYEXP_RCON_LUT_EN undefined: Rcon SHALL be a register initialised to 01 at key transfer and updated by GF(2^8) xtime (shift left, xor 1B on carry) per round-key transfer.
REQ-027 Both builds SHALL produce bit-identical outputs cycle for cycle.

Verification
REQ-028 Key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> RK1 a0fafe1788542cb123a339392a6c7605, RK10 d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1 at transfer+11.
REQ-029 Key all-zero -> RK1 62636363626363636263636362636363, RK2 9b9898c9f9fbfbaa9b9898c9f9fbfbaa.
REQ-030 FIPS key, rk_ready low for 5 cycles at index 4 -> rk_data/rk_index frozen at index 4; sequence resumes unchanged; RK10 still d014f9a8....
REQ-031 key_valid held high with alternating keys during EXPAND -> ignored; second key accepted only at transfer+12; its RK0 appears at transfer+13.
REQ-032 rst_n pulsed low at index 6 -> rk_valid=0, key_ready=1 immediately; next key expands correctly from RK0.
REQ-033 Run REQ-028 in both KEYEXP_RCON_LUT_EN builds -> identical traces.
